// File: rtl/masked_ram_wq.sv
// Byte-lane masked RAM fronted by a small write queue whose entries commit
// after a per-entry delay or on a rising trigger, one commit per clock edge.
module masked_ram_wq #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int LANE   = 4,
    parameter int QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DW-1:0]                wr_data,
    input  logic [DW/LANE-1:0]           wr_lane,
    input  logic [3:0]                   wr_delay,
    input  logic                         wr_trig,
    input  logic                         trig,
    input  logic [AW-1:0]                rd_addr,
    output logic [DW-1:0]                rd_data,
    output logic [$clog2(QDEPTH+1)-1:0]  pend_cnt,
    output logic                         commit_valid,
    output logic [AW-1:0]                commit_addr
);

    localparam int NL    = DW / LANE;
    localparam int CW    = $clog2(QDEPTH + 1);
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NL-1:0] lane;
        logic          tmode;  // 1 = waits for a trigger rise
        logic          tdue;   // trigger already seen, waiting for its turn
        logic [3:0]    cnt;
    } entry_t;

    // Queue is kept compacted: slot 0 is the oldest, slots >= pend_q are empty.
    entry_t          q_q   [QDEPTH];
    entry_t          q_d   [QDEPTH];
    entry_t          upd   [QDEPTH];
    entry_t          nxt   [QDEPTH];
    logic [CW-1:0]   pend_q, pend_d;
    logic            trig_q;
    logic            trig_rise;
    logic [QDEPTH-1:0] due;
    logic            commit;
    entry_t          c_ent;
    logic            accept;
    logic [CW-1:0]   slot;
    logic [DW-1:0]   lane_mask;
    logic [DW-1:0]   merged;
    logic [DW-1:0]   mem   [DEPTH];
    logic [DW-1:0]   rd_q;
    logic            cv_q;
    logic [AW-1:0]   ca_q;

    assign trig_rise    = trig & ~trig_q;
    assign wr_ready     = (pend_q < CW'(QDEPTH));
    assign accept       = wr_valid & wr_ready;
    assign rd_data      = rd_q;
    assign pend_cnt     = pend_q;
    assign commit_valid = cv_q;
    assign commit_addr  = ca_q;

    always_comb begin
        due = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            due[i] = (CW'(i) < pend_q) &&
                     (q_q[i].tmode ? (q_q[i].tdue | trig_rise) : (q_q[i].cnt == 4'd0));
        end
    end

    // Lowest due slot wins, which is the oldest due entry.
    always_comb begin
        commit = 1'b0;
        c_ent  = '0;
        for (int i = QDEPTH - 1; i >= 0; i--) begin
            if (due[i]) begin
                commit = 1'b1;
                c_ent  = q_q[i];
            end
        end
    end

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it holding a value and no latch is inferred.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < NL; k++) begin
            lane_mask[k*LANE +: LANE] = {LANE{c_ent.lane[k]}};
        end
        merged = (mem[c_ent.addr] & ~lane_mask) | (c_ent.data & lane_mask);
    end

    // Per-entry aging: delay counters count down to zero and park there,
    // trigger entries latch a rise so they stay due until they win arbitration.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            upd[i] = q_q[i];
            if (!q_q[i].tmode && q_q[i].cnt != 4'd0) begin
                upd[i].cnt = q_q[i].cnt - 4'd1;
            end
            if (q_q[i].tmode && trig_rise) begin
                upd[i].tdue = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
            nxt[i] = upd[i + 1];
        end
        nxt[QDEPTH-1] = '0;
    end

    // Remove the committed slot by shifting everything above it down one,
    // then append the accepted write behind the survivors.
    always_comb begin
        logic shift;
        shift = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            shift  = shift | due[i];
            q_d[i] = shift ? nxt[i] : upd[i];
        end
        slot = pend_q - CW'(commit);
        for (int i = 0; i < QDEPTH; i++) begin
            if (accept && CW'(i) == slot) begin
                q_d[i] = '{addr:  wr_addr,
                           data:  wr_data,
                           lane:  wr_lane,
                           tmode: wr_trig,
                           tdue:  1'b0,
                           cnt:   wr_delay};
            end
        end
        pend_d = pend_q - CW'(commit) + CW'(accept);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= '0;
            end
            pend_q <= '0;
            trig_q <= 1'b0;
            rd_q   <= '0;
            cv_q   <= 1'b0;
            ca_q   <= '0;
        end else begin
            q_q    <= q_d;
            pend_q <= pend_d;
            trig_q <= trig;
            rd_q   <= (commit && c_ent.addr == rd_addr) ? merged : mem[rd_addr];
            cv_q   <= commit;
            if (commit) begin
                ca_q <= c_ent.addr;
            end
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst_n and a
    // reset port here would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[c_ent.addr] <= merged;
        end
    end

endmodule

// File: tb/tb_masked_ram_wq.sv
// Self-checking bench for masked_ram_wq: queue-based reference model compared
// every cycle, directed scenarios with literal values, then random traffic.
module tb_masked_ram_wq;

    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] wr_lane = '0;
    logic [3:0] wr_delay = '0;
    logic       wr_trig = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [2:0] pend_cnt;
    logic       commit_valid;
    logic [7:0] commit_addr;

    int total = 0;
    int bad   = 0;

    masked_ram_wq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_lane      (wr_lane),
        .wr_delay     (wr_delay),
        .wr_trig      (wr_trig),
        .trig         (trig),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pend_cnt     (pend_cnt),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [1:0] lanes;
        bit         tmode;
        int         cnt;
        bit         due;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] mmem  [256];
    bit         known [256];
    int         exp_pend = 0;
    bit         exp_cv = 0;
    logic [7:0] exp_ca = '0;
    logic [7:0] exp_rd = '0;
    bit         exp_rd_known = 0;
    bit         tprev = 0;

    task automatic model_reset();
        mq.delete();
        exp_pend     = 0;
        exp_cv       = 0;
        exp_ca       = '0;
        exp_rd       = '0;
        exp_rd_known = 1;
        tprev        = 0;
    endtask

    task automatic model_step();
        bit         rise;
        bit         acc;
        int         ci;
        logic [7:0] m;
        logic [7:0] a;
        ent_t       e;
        rise = trig && !tprev;
        acc  = wr_valid && (mq.size() < QD);
        ci   = -1;
        foreach (mq[i]) begin
            if (mq[i].tmode) begin
                if (rise) mq[i].due = 1;
            end else begin
                mq[i].due = (mq[i].cnt == 0);
            end
            if (mq[i].due && ci < 0) ci = i;
        end
        if (ci >= 0) begin
            a = mq[ci].addr;
            m = {{4{mq[ci].lanes[1]}}, {4{mq[ci].lanes[0]}}};
            mmem[a]  = (mmem[a] & ~m) | (mq[ci].data & m);
            known[a] = known[a] || (mq[ci].lanes == 2'b11);
            exp_cv   = 1;
            exp_ca   = a;
            mq.delete(ci);
        end else begin
            exp_cv = 0;
        end
        foreach (mq[i]) begin
            if (!mq[i].tmode && mq[i].cnt > 0) mq[i].cnt--;
        end
        if (acc) begin
            e.addr  = wr_addr;
            e.data  = wr_data;
            e.lanes = wr_lane;
            e.tmode = wr_trig;
            e.cnt   = int'(wr_delay);
            e.due   = 0;
            mq.push_back(e);
        end
        exp_pend     = mq.size();
        exp_rd       = mmem[rd_addr];
        exp_rd_known = known[rd_addr];
        tprev        = trig;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare process: outputs are registered, so the falling edge sees them settled.
    initial begin
        forever begin
            @(negedge clk);
            check("wr_ready", wr_ready, (exp_pend < QD));
            check("pend_cnt", pend_cnt, exp_pend);
            check("commit_valid", commit_valid, exp_cv);
            check("commit_addr", commit_addr, exp_ca);
            if (exp_rd_known) check("rd_data", rd_data, exp_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [1:0] l,
                      input logic [3:0] dl, input logic tm);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_lane  = l;
        wr_delay = dl;
        wr_trig  = tm;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mmem[i]  = '0;
            known[i] = 0;
        end
        step();
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_pend", pend_cnt, 3'd0);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_cv", commit_valid, 1'b0);
        check("rst_ca", commit_addr, 8'h00);
        rst_n = 1'b1;

        // Known contents for the low addresses used below.
        for (int a = 0; a < 32; a++) begin
            wr(8'(a), 8'($urandom), 2'b11, 4'd0, 1'b0);
            step();
        end
        idle();
        step(2);

        // Full write then upper-lane merge.
        rd_addr = 8'd3;
        wr(8'd3, 8'h97, 2'b11, 4'd0, 1'b0);
        step();
        idle();
        step();
        check("r19_rd_full", rd_data, 8'h97);
        check("r19_cv", commit_valid, 1'b1);
        check("r19_ca", commit_addr, 8'd3);
        wr(8'd3, 8'h30, 2'b10, 4'd0, 1'b0);
        step();
        idle();
        step();
        check("r19_rd_merge", rd_data, 8'h37);

        // Two delayed writes to the same address, one edge apart.
        wr(8'd3, 8'h92, 2'b11, 4'd0, 1'b0);
        step();
        idle();
        step();
        check("r20_pre", rd_data, 8'h92);
        wr(8'd3, 8'h07, 2'b11, 4'd1, 1'b0);
        step();
        wr(8'd3, 8'h30, 2'b10, 4'd1, 1'b0);
        step();
        idle();
        check("r20_e1_cv", commit_valid, 1'b0);
        step();
        check("r20_e2_rd", rd_data, 8'h07);
        check("r20_e2_cv", commit_valid, 1'b1);
        check("r20_e2_ca", commit_addr, 8'd3);
        step();
        check("r20_e3_rd", rd_data, 8'h37);
        check("r20_e3_cv", commit_valid, 1'b1);
        step();
        check("r20_after_cv", commit_valid, 1'b0);
        check("r20_hold_ca", commit_addr, 8'd3);

        // Trigger-mode entry waits for a rise, and only one rise.
        trig = 1'b0;
        wr(8'd3, 8'h99, 2'b11, 4'd9, 1'b1);
        step();
        idle();
        step(10);
        check("r21_wait_pend", pend_cnt, 3'd1);
        check("r21_wait_rd", rd_data, 8'h37);
        trig = 1'b1;
        step();
        check("r21_rise_rd", rd_data, 8'h99);
        check("r21_rise_cv", commit_valid, 1'b1);
        check("r21_rise_pend", pend_cnt, 3'd0);
        step(3);
        check("r21_held_cv", commit_valid, 1'b0);
        trig = 1'b0;
        step();

        // Fill the queue, drop an overflow write, drain oldest first.
        for (int i = 0; i < 4; i++) begin
            wr(8'(10 + i), 8'(8'hA1 + i), 2'b11, 4'd0, 1'b1);
            step();
        end
        check("r22_full_pend", pend_cnt, 3'd4);
        check("r22_full_ready", wr_ready, 1'b0);
        wr(8'd14, 8'hEE, 2'b11, 4'd0, 1'b0);
        step();
        check("r22_drop_pend", pend_cnt, 3'd4);
        idle();
        trig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("r22_drain_pend", pend_cnt, 3'(3 - i));
            check("r22_drain_ca", commit_addr, 8'(10 + i));
            check("r22_drain_ready", wr_ready, 1'b1);
        end
        trig = 1'b0;
        step();

        // Two delay entries due at the same edge serialize by age.
        wr(8'd20, 8'h5A, 2'b11, 4'd2, 1'b0);
        step();
        wr(8'd21, 8'hA5, 2'b01, 4'd1, 1'b0);
        step();
        idle();
        step();
        check("r23_e2_cv", commit_valid, 1'b0);
        step();
        check("r23_e3_ca", commit_addr, 8'd20);
        check("r23_e3_cv", commit_valid, 1'b1);
        step();
        check("r23_e4_ca", commit_addr, 8'd21);
        check("r23_e4_cv", commit_valid, 1'b1);
        step();
        check("r23_e5_cv", commit_valid, 1'b0);

        // Reset with entries pending: discarded, memory intact.
        for (int i = 0; i < 3; i++) begin
            wr(8'(30 + i), 8'hC3, 2'b11, 4'd0, 1'b1);
            step();
        end
        idle();
        check("r24_pend", pend_cnt, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        check("r24_rst_pend", pend_cnt, 3'd0);
        check("r24_rst_ready", wr_ready, 1'b1);
        check("r24_rst_rd", rd_data, 8'h00);
        check("r24_rst_cv", commit_valid, 1'b0);
        check("r24_rst_ca", commit_addr, 8'h00);
        step();
        rst_n = 1'b1;
        trig  = 1'b1;
        rd_addr = 8'd3;
        step();
        check("r24_rel_cv", commit_valid, 1'b0);
        check("r24_rel_rd", rd_data, 8'h99);
        step(3);
        check("r24_no_commit", commit_valid, 1'b0);
        check("r24_no_pend", pend_cnt, 3'd0);
        trig = 1'b0;
        step();

        // Random traffic against the model, with one mid-cycle reset.
        for (int c = 0; c < 1500; c++) begin
            wr_valid = ($urandom_range(0, 99) < 60);
            wr_addr  = 8'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            wr_lane  = 2'($urandom);
            wr_delay = 4'($urandom_range(0, 5));
            wr_trig  = ($urandom_range(0, 99) < 30);
            trig     = ($urandom_range(0, 99) < 20) ? ~trig : trig;
            rd_addr  = 8'($urandom_range(0, 7));
            if (c == 700) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            step();
        end
        idle();
        trig = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/masked_ram_wq.md
MASKED_RAM_WQ -- requirements
Module: masked_ram_wq

Interface
REQ-001 The module SHALL have parameter DW, default 8, the memory word width in bits.
REQ-002 The module SHALL have parameter AW, default 8, the address width, giving depth 2**AW.
REQ-003 The module SHALL have parameter LANE, default 4, the lane width in bits; DW is a multiple of LANE, NL=DW/LANE.
REQ-004 The module SHALL have parameter QDEPTH, default 4, the number of pending-write slots.
REQ-005 One clock and an asynchronous, active-low reset SHALL be used, with these ports:
clk  in  1  clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  queue can accept; equals pend_cnt<QDEPTH
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_lane  in  NL  lane enable; bit k covers data[k*LANE+:LANE]
wr_delay  in  4  extra cycles before commit (delay mode)
wr_trig  in  1  1 = trigger mode, wr_delay ignored
trig  in  1  commit event for trigger-mode entries
rd_addr  in  AW  read address
rd_data  out  DW  registered read data
pend_cnt  out  clog2(QDEPTH+1)  valid queue entries
commit_valid  out  1  one-cycle pulse: a commit happened at the last edge
commit_addr  out  AW  address of that commit

Function
REQ-006 A write SHALL be accepted at edge E0 when wr_valid and wr_ready are both high; it stores addr, data, lane mask, mode and a counter loaded with wr_delay; wr_valid while wr_ready is low SHALL be ignored.
REQ-007 Each delay-mode entry SHALL be due at an edge where its counter is 0; otherwise the counter decrements at that edge, so an uncontended entry commits at edge E0+wr_delay+1.
REQ-008 trig_rise SHALL be trig high with the registered previous trig low; at an edge with trig_rise, every trigger-mode entry already valid before that edge becomes due and stays due until committed.
REQ-009 An entry accepted at edge E SHALL NOT be due or commit at E.
REQ-010 At most one entry SHALL commit per edge, the oldest due entry (acceptance order); other due entries remain due and commit on following edges in age order.
REQ-011 Commit SHALL write only enabled lanes: mem[a] = (mem[a] & ~M) | (data & M), M the lane mask expanded to DW bits; mask all-zero still commits with no data change.
REQ-012 A younger entry SHALL be allowed to commit before an older non-due entry to the same address; the final value is the merge of commits in commit order.
REQ-013 rd_data SHALL update every edge to mem[rd_addr] including any commit at the same edge (write-first), latency one cycle.
REQ-014 commit_valid SHALL be high for exactly the cycle after each commit edge, commit_addr holding that entry's address; both SHALL hold their values otherwise, with commit_valid low.
REQ-015 pend_cnt SHALL add 1 per accept and subtract 1 per commit, both possible at one edge; wr_ready derives from registered pend_cnt, so a slot freed at edge E is usable from edge E+1.

Reset
REQ-016 While rst_n is low all queue entries SHALL be invalidated and pend_cnt=0, wr_ready=1, rd_data=0, commit_valid=0, commit_addr=0, previous-trig register=0.
REQ-017 Memory contents SHALL NOT be altered by reset; entries pending at reset assertion SHALL be discarded and never commit.
REQ-018 With trig high at the first edge after reset release, trig_rise SHALL be asserted.

Verification
REQ-019 Write addr 3, 0x97, lanes 11, delay 0 at E0 with rd_addr=3 -> rd_data=0x97 after E1; then lanes 10, data 0x30, delay 0 -> rd_data 0x37.
REQ-020 mem[3]=0x92; accept 0x07 lanes 11 delay 1 at E0, 0x30 lanes 10 delay 1 at E1 -> rd_data 0x07 after E2, 0x37 after E3, commit_valid pulses after E2 and E3 with commit_addr=3.
REQ-021 Accept 0x99 trigger mode at addr 3, hold trig low 10 cycles -> no commit, pend_cnt=1; raise trig -> commit at that edge, rd_data 0x99; holding trig high causes no further commit.
REQ-022 Fill 4 trigger-mode entries -> pend_cnt=4, wr_ready=0, 5th wr_valid dropped; trig rise -> commits on 4 consecutive edges oldest first, pend_cnt 3,2,1,0, wr_ready=1 from the first commit edge.
REQ-023 Two delay entries becoming due at the same edge -> older commits at that edge, younger at the next; single pulse each.
REQ-024 Three entries pending, pulse rst_n low mid-cycle -> outputs immediately at reset values, no commit after release, previously committed memory values still read back.
